// File: rtl/arm_alu.sv
// arm_alu: ARM7TDMI-style registered 32-bit integer ALU.
// Operands and opcode are captured on the rising clock edge; the result,
// the architectural NZCV flags and the writeback strobes appear one cycle
// later. The flag register doubles as the carry source for ADC/SBC/RSC.
module arm_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzcv,
    output logic             result_writeback,
    output logic             nzcv_writeback
);

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_EOR = 4'd1,
        OP_SUB = 4'd2,
        OP_RSB = 4'd3,
        OP_ADD = 4'd4,
        OP_ADC = 4'd5,
        OP_SBC = 4'd6,
        OP_RSC = 4'd7,
        OP_TST = 4'd8,
        OP_TEQ = 4'd9,
        OP_CMP = 4'd10,
        OP_CMN = 4'd11,
        OP_ORR = 4'd12,
        OP_MOV = 4'd13,
        OP_BIC = 4'd14,
        OP_MVN = 4'd15
    } aluOp_e;

    aluOp_e           aluOp;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic             resultWb_q, resultWb_d;
    logic             nzcvWb_q;

    logic [WIDTH-1:0] addX;
    logic [WIDTH-1:0] addY;
    logic             addCin;
    logic             isArith;
    logic [WIDTH:0]   addSum;
    logic [WIDTH-1:0] logicRes;
    logic             carryIn;
    logic             addCarry;
    logic             addOverflow;

    assign aluOp   = aluOp_e'(alu_control);
    assign carryIn = nzcv_q[1];

    // Steer both operands into the single adder; subtracts invert the
    // subtrahend, with the carry-in supplying the +1 or the registered C.
    always_comb begin
        addX    = operand_a;
        addY    = operand_b;
        addCin  = 1'b0;
        isArith = 1'b1;
        case (aluOp)
            OP_ADD, OP_CMN: begin
                addX   = operand_a;
                addY   = operand_b;
                addCin = 1'b0;
            end
            OP_ADC: begin
                addX   = operand_a;
                addY   = operand_b;
                addCin = carryIn;
            end
            OP_SUB, OP_CMP: begin
                addX   = operand_a;
                addY   = ~operand_b;
                addCin = 1'b1;
            end
            OP_SBC: begin
                addX   = operand_a;
                addY   = ~operand_b;
                addCin = carryIn;
            end
            OP_RSB: begin
                addX   = operand_b;
                addY   = ~operand_a;
                addCin = 1'b1;
            end
            OP_RSC: begin
                addX   = operand_b;
                addY   = ~operand_a;
                addCin = carryIn;
            end
            default: begin
                isArith = 1'b0;
            end
        endcase
    end

    // One WIDTH+1 bit adder; the top bit is the ARM carry (1 = no borrow on subtracts).
    assign addSum      = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
    assign addCarry    = addSum[WIDTH];
    assign addOverflow = (addX[WIDTH-1] == addY[WIDTH-1]) &&
                         (addSum[WIDTH-1] != addX[WIDTH-1]);

    // Bitwise operations share one mux; arithmetic opcodes never use this value.
    always_comb begin
        logicRes = '0;
        case (aluOp)
            OP_AND, OP_TST: logicRes = operand_a & operand_b;
            OP_EOR, OP_TEQ: logicRes = operand_a ^ operand_b;
            OP_ORR:         logicRes = operand_a | operand_b;
            OP_MOV:         logicRes = operand_b;
            OP_BIC:         logicRes = operand_a & ~operand_b;
            OP_MVN:         logicRes = ~operand_b;
            default:        logicRes = '0;
        endcase
    end

    // Next-state result, flags and result strobe; logical ops keep the old C and V.
    always_comb begin
        result_d   = isArith ? addSum[WIDTH-1:0] : logicRes;
        nzcv_d     = nzcv_q;
        nzcv_d[3]  = result_d[WIDTH-1];
        nzcv_d[2]  = (result_d == '0);
        if (isArith) begin
            nzcv_d[1] = addCarry;
            nzcv_d[0] = addOverflow;
        end
        resultWb_d = !((aluOp == OP_TST) || (aluOp == OP_TEQ) ||
                       (aluOp == OP_CMP) || (aluOp == OP_CMN));
    end

    // Output and flag registers; reset clears everything, including the carry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q   <= '0;
            nzcv_q     <= 4'b0000;
            resultWb_q <= 1'b0;
            nzcvWb_q   <= 1'b0;
        end else begin
            result_q   <= result_d;
            nzcv_q     <= nzcv_d;
            resultWb_q <= resultWb_d;
            nzcvWb_q   <= 1'b1;
        end
    end

    assign result           = result_q;
    assign nzcv             = nzcv_q;
    assign result_writeback = resultWb_q;
    assign nzcv_writeback   = nzcvWb_q;

endmodule

// File: tb/tb_arm_alu.sv
// tb_arm_alu: directed and randomized checking of arm_alu against a
// behavioural model that evaluates each opcode with wide integer arithmetic.
module tb_arm_alu;

    logic        clk;
    logic        reset;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_control;
    logic [31:0] result;
    logic [3:0]  nzcv;
    logic        result_writeback;
    logic        nzcv_writeback;

    int checks = 0;
    int errors = 0;

    logic [31:0] expResult = '0;
    logic [3:0]  expNzcv   = '0;
    logic        expRwb    = 1'b0;
    logic        expFwb    = 1'b0;
    logic        modelLive = 1'b0;

    arm_alu #(.WIDTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .alu_control      (alu_control),
        .result           (result),
        .nzcv             (nzcv),
        .result_writeback (result_writeback),
        .nzcv_writeback   (nzcv_writeback)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: arithmetic done on 64-bit integers, with carry
    // meaning "unsigned result fits / no borrow" and overflow meaning
    // "signed result falls outside the 32-bit range".
    always @(posedge clk or negedge reset) begin
        longint ua, ub, sa, sb, u, s, borrowIn;
        logic   isSub, arith, cIn;
        logic [31:0] r;
        if (!reset) begin
            expResult = '0;
            expNzcv   = '0;
            expRwb    = 1'b0;
            expFwb    = 1'b0;
            modelLive = 1'b1;
        end else begin
            cIn      = expNzcv[1];
            borrowIn = cIn ? 0 : 1;
            ua = longint'(operand_a);
            ub = longint'(operand_b);
            sa = longint'($signed(operand_a));
            sb = longint'($signed(operand_b));
            arith = 1'b1;
            isSub = 1'b0;
            u = 0;
            s = 0;
            r = '0;
            case (alu_control)
                4'd4, 4'd11: begin u = ua + ub;              s = sa + sb;              end
                4'd5:        begin u = ua + ub + cIn;        s = sa + sb + cIn;        end
                4'd2, 4'd10: begin u = ua - ub;              s = sa - sb;              isSub = 1'b1; end
                4'd6:        begin u = ua - ub - borrowIn;   s = sa - sb - borrowIn;   isSub = 1'b1; end
                4'd3:        begin u = ub - ua;              s = sb - sa;              isSub = 1'b1; end
                4'd7:        begin u = ub - ua - borrowIn;   s = sb - sa - borrowIn;   isSub = 1'b1; end
                4'd0, 4'd8:  begin arith = 1'b0; r = operand_a & operand_b;  end
                4'd1, 4'd9:  begin arith = 1'b0; r = operand_a ^ operand_b;  end
                4'd12:       begin arith = 1'b0; r = operand_a | operand_b;  end
                4'd13:       begin arith = 1'b0; r = operand_b;              end
                4'd14:       begin arith = 1'b0; r = operand_a & ~operand_b; end
                default:     begin arith = 1'b0; r = ~operand_b;             end
            endcase
            if (arith) begin
                r = u[31:0];
                expNzcv[1] = isSub ? (u >= 0) : (u >= 64'sh1_0000_0000);
                expNzcv[0] = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
            end
            expResult  = r;
            expNzcv[3] = r[31];
            expNzcv[2] = (r == 32'd0);
            expRwb     = !(alu_control >= 4'd8 && alu_control <= 4'd11);
            expFwb     = 1'b1;
        end
    end

    // Every falling edge the DUT outputs must match the model.
    always @(negedge clk) begin
        if (modelLive) begin
            checks++;
            if (result !== expResult || nzcv !== expNzcv ||
                result_writeback !== expRwb || nzcv_writeback !== expFwb) begin
                errors++;
                $display("[TB] FAIL model t=%0t op=%0d got res=%h nzcv=%b rwb=%b fwb=%b expected res=%h nzcv=%b rwb=%b fwb=%b",
                         $time, alu_control, result, nzcv, result_writeback, nzcv_writeback,
                         expResult, expNzcv, expRwb, expFwb);
            end
        end
    end

    // Present one operation and let it be captured; returns 1 unit after the edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_control = op;
        operand_a   = a;
        operand_b   = b;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectation for the current outputs.
    task automatic checkOutput(input string name, input logic [31:0] eRes, input logic [3:0] eNzcv,
                               input logic eRwb, input logic eFwb);
        checks++;
        if (result !== eRes || nzcv !== eNzcv || result_writeback !== eRwb || nzcv_writeback !== eFwb) begin
            errors++;
            $display("[TB] FAIL %s got res=%h nzcv=%b rwb=%b fwb=%b expected res=%h nzcv=%b rwb=%b fwb=%b",
                     name, result, nzcv, result_writeback, nzcv_writeback, eRes, eNzcv, eRwb, eFwb);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0)
            return specials[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    initial begin
        reset       = 1'b1;
        operand_a   = '0;
        operand_b   = '0;
        alu_control = 4'd4;
        #2 reset = 1'b0;
        #1;
        checkOutput("reset", 32'h0, 4'b0000, 1'b0, 1'b0);
        reset = 1'b1;

        applyStimulus(4'd4,  32'd10,         32'd20); checkOutput("add",      32'd30,         4'b0000, 1, 1);
        applyStimulus(4'd2,  32'd30,         32'd10); checkOutput("sub",      32'd20,         4'b0010, 1, 1);
        applyStimulus(4'd3,  32'd10,         32'd20); checkOutput("rsb",      32'd10,         4'b0010, 1, 1);
        applyStimulus(4'd2,  32'd3,          32'd5);  checkOutput("sub_neg",  32'hFFFF_FFFE, 4'b1000, 1, 1);
        applyStimulus(4'd4,  32'h7FFF_FFFF,  32'd1);  checkOutput("add_ovf",  32'h8000_0000, 4'b1001, 1, 1);
        applyStimulus(4'd4,  32'hFFFF_FFFF,  32'd1);  checkOutput("add_wrap", 32'h0,         4'b0110, 1, 1);
        applyStimulus(4'd5,  32'd2,          32'd3);  checkOutput("adc_c1",   32'd6,          4'b0000, 1, 1);
        applyStimulus(4'd6,  32'h7FFF_FFFF,  32'd5);  checkOutput("sbc_c0",   32'h7FFF_FFF9, 4'b0010, 1, 1);
        applyStimulus(4'd10, 32'd5,          32'd3);  checkOutput("cmp",      32'd2,          4'b0010, 0, 1);
        applyStimulus(4'd11, 32'h7FFF_FFFF,  32'd1);  checkOutput("cmn",      32'h8000_0000, 4'b1001, 0, 1);
        applyStimulus(4'd8,  32'd0,          32'd0);  checkOutput("tst",      32'h0,         4'b0101, 0, 1);
        applyStimulus(4'd9,  32'd255,        32'd255);checkOutput("teq",      32'h0,         4'b0101, 0, 1);
        applyStimulus(4'd0,  32'd8,          32'd5);  checkOutput("and",      32'h0,         4'b0101, 1, 1);
        applyStimulus(4'd1,  32'd15,         32'd7);  checkOutput("eor",      32'd8,          4'b0001, 1, 1);
        applyStimulus(4'd12, 32'd10,         32'd20); checkOutput("orr",      32'd30,         4'b0001, 1, 1);
        applyStimulus(4'd14, 32'd255,        32'd85); checkOutput("bic",      32'd170,        4'b0001, 1, 1);
        applyStimulus(4'd13, 32'd0,          32'd42); checkOutput("mov",      32'd42,         4'b0001, 1, 1);
        applyStimulus(4'd15, 32'd0,          32'd0);  checkOutput("mvn",      32'hFFFF_FFFF, 4'b1001, 1, 1);
        applyStimulus(4'd4,  32'hFFFF_FFFF,  32'd2);  checkOutput("set_c",    32'd1,          4'b0010, 1, 1);

        alu_control = 4'd5;
        operand_a   = 32'd1;
        operand_b   = 32'd1;
        #1 reset = 1'b0;
        #1 checkOutput("async_rst", 32'h0, 4'b0000, 1'b0, 1'b0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 checkOutput("adc_after_rst", 32'd2, 4'b0000, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            alu_control = 4'($urandom_range(0, 15));
            operand_a   = pickOperand();
            operand_b   = pickOperand();
            if ($urandom_range(0, 99) == 0) begin
                #1 reset = 1'b0;
                #2 reset = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
